// File: rtl/keypad_defs.sv
// Shared keypad constants: key codes, debounce FSM encoding, default timing parameters.
// Game-level logic compares key_code against these names rather than raw nibbles.
package keypad_defs;

  localparam int SCAN_DWELL_DEFAULT     = 2;
  localparam int DEBOUNCE_SCANS_DEFAULT = 3;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    DEB_IDLE  = 2'd0,
    DEB_PRESS = 2'd1,
    DEB_HELD  = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_e;

  // Physical layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_A;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_B;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: accepts a press/release after DEBOUNCE_SCANS identical scan results.
// Outputs registered; key_press fires the cycle after the qualifying scan_done, no backpressure.
import keypad_defs::*;

module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_done,
  input  logic       raw_valid,
  input  logic [3:0] raw_code,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_press
);

  localparam logic [2:0] CNT_DONE = 3'(DEBOUNCE_SCANS);

  deb_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic       valid_q, valid_d;
  logic [3:0] code_q, code_d;
  logic       press_q, press_d;
  logic       raw_match;
  logic [2:0] cnt_inc;

  assign raw_match = raw_valid && (raw_code == cand_q);
  assign cnt_inc   = cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    valid_d = valid_q;
    code_d  = code_q;
    press_d = 1'b0;
    if (scan_done) begin
      case (state_q)
        DEB_IDLE: begin
          if (raw_valid) begin
            cand_d = raw_code;
            cnt_d  = 3'd1;
            if (CNT_DONE == 3'd1) begin
              state_d = DEB_HELD;
              valid_d = 1'b1;
              code_d  = raw_code;
              press_d = 1'b1;
            end else begin
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (raw_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = DEB_HELD;
              valid_d = 1'b1;
              code_d  = cand_q;
              press_d = 1'b1;
            end
          end else begin
            state_d = DEB_IDLE;
            cnt_d   = 3'd0;
          end
        end
        DEB_HELD: begin
          if (!raw_match) begin
            cnt_d = 3'd1;
            if (CNT_DONE == 3'd1) begin
              state_d = DEB_IDLE;
              valid_d = 1'b0;
              code_d  = 4'h0;
            end else begin
              state_d = DEB_REL;
            end
          end
        end
        default: begin
          // Bouncing back to the held key resumes HELD silently; no second press.
          if (raw_match) begin
            state_d = DEB_HELD;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = DEB_IDLE;
              cnt_d   = 3'd0;
              valid_d = 1'b0;
              code_d  = 4'h0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEB_IDLE;
      cnt_q   <= 3'd0;
      cand_q  <= 4'h0;
      valid_q <= 1'b0;
      code_q  <= 4'h0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      press_q <= press_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_press = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, ghost-rejecting encoder, debounce.
// A scan takes 4*SCAN_DWELL cycles; outputs are registered, no backpressure.
import keypad_defs::*;

module keypad_scanner #(
  parameter int SCAN_DWELL     = SCAN_DWELL_DEFAULT,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_press,
  output logic       key_star_rise
);

  localparam logic [3:0] DWELL_LAST = 4'(SCAN_DWELL - 1);
  // The synchronizer is two cycles deep; with a 2-cycle dwell the sampled rows
  // still belong to the previously driven column.
  localparam logic [1:0] COL_LAG = (SCAN_DWELL >= 3) ? 2'd0 : 2'd1;

  logic [3:0] row_s1_q, row_s1_d;
  logic [3:0] row_s2_q, row_s2_d;
  logic [3:0] dwell_q, dwell_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] hits_q, hits_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic       scan_done_q, scan_done_d;
  logic       raw_valid_q, raw_valid_d;
  logic [3:0] raw_code_q, raw_code_d;

  logic       sample;
  logic [1:0] sample_col;
  logic [3:0] row_low;
  logic [1:0] hits_n;
  logic [3:0] code_n;

  assign sample     = (dwell_q == DWELL_LAST);
  assign sample_col = col_idx_q - COL_LAG;
  assign row_low    = ~row_s2_q;
  assign col        = ~(4'b0001 << col_idx_q);

  // Fold this column's rows into the running scan; hit count saturates at 2.
  always_comb begin
    hits_n = (col_idx_q == 2'd0) ? 2'd0 : hits_q;
    code_n = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (row_low[r]) begin
        if (hits_n != 2'd2) hits_n = hits_n + 2'd1;
        code_n = key_map(2'(r), sample_col);
      end
    end
  end

  always_comb begin
    row_s1_d    = row;
    row_s2_d    = row_s1_q;
    dwell_d     = sample ? 4'd0 : dwell_q + 4'd1;
    col_idx_d   = col_idx_q;
    hits_d      = hits_q;
    acc_code_d  = acc_code_q;
    scan_done_d = 1'b0;
    raw_valid_d = raw_valid_q;
    raw_code_d  = raw_code_q;
    if (sample) begin
      col_idx_d  = col_idx_q + 2'd1;
      hits_d     = hits_n;
      acc_code_d = code_n;
      if (col_idx_q == 2'd3) begin
        scan_done_d = 1'b1;
        raw_valid_d = (hits_n == 2'd1);
        raw_code_d  = (hits_n == 2'd1) ? code_n : 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      dwell_q     <= 4'd0;
      col_idx_q   <= 2'd0;
      hits_q      <= 2'd0;
      acc_code_q  <= 4'h0;
      scan_done_q <= 1'b0;
      raw_valid_q <= 1'b0;
      raw_code_q  <= 4'h0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      acc_code_q  <= acc_code_d;
      scan_done_q <= scan_done_d;
      raw_valid_q <= raw_valid_d;
      raw_code_q  <= raw_code_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_done (scan_done_q),
    .raw_valid (raw_valid_q),
    .raw_code  (raw_code_q),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_press (key_press)
  );

  assign key_star_rise = key_press && (key_code == KEY_STAR);

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a matrix model drives rows from col; presses queue expected codes
// and a negedge monitor pops and checks them whenever key_press fires.
module tb_keypad_scanner;
  import keypad_defs::*;

  localparam int K_1 = 0, K_A = 3, K_5 = 5, K_B = 7, K_9 = 10;
  localparam int K_STAR = 12, K_0 = 13, K_HASH = 14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_press, key_star_rise;
  logic [15:0] keys;

  int tests = 0, fails = 0;
  int press_cnt = 0, star_cnt = 0, inv_errs = 0;
  bit valid_seen, valid_fell;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row           (row),
    .col           (col),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_press     (key_press),
    .key_star_rise (key_star_rise)
  );

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0] e;
    if (key_press) begin
      press_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_press: got code 0x%0h, expected no press", key_code);
      end else begin
        e = exp_q.pop_front();
        check("press_code", {4'h0, key_code}, {4'h0, e});
        check("star_rise_with_press", {7'h0, key_star_rise}, {7'h0, (e == KEY_STAR)});
      end
    end
    if (key_star_rise) star_cnt++;
    if (key_star_rise && !key_press) inv_errs++;
    if (!key_valid && key_code != 4'h0) inv_errs++;
    if (key_valid) valid_seen = 1'b1;
    else valid_fell = 1'b1;
  end

  task automatic wait_level(input logic lvl, input int bound, output int lat);
    lat = 0;
    while (key_valid !== lvl && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    if (key_valid !== lvl) begin
      tests++;
      fails++;
      $display("FAIL wait_key_valid: got %0b after %0d cycles, expected %0b", key_valid, lat, lvl);
    end
  endtask

  // Returns at the negedge of the first cycle a new scan drives col=1110.
  task automatic align_scan();
    logic [3:0] pc;
    pc = col;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && pc == 4'b0111) return;
      pc = col;
    end
    tests++;
    fails++;
    $display("FAIL align_scan: got col 0x%0h, expected rotation into 0xe", col);
  endtask

  initial begin
    int lat, p0, s0;
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, p0, s0;
    rst_n = 1'b0;
    keys = '0;
    valid_seen = 1'b0;
    valid_fell = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_col", {4'h0, col}, 8'h0E);
    check("reset_valid", {7'h0, key_valid}, 8'h00);
    check("reset_code", {4'h0, key_code}, 8'h00);
    check("reset_press", {7'h0, key_press}, 8'h00);
    check("reset_star", {7'h0, key_star_rise}, 8'h00);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // '*' held steadily
    p0 = press_cnt;
    s0 = star_cnt;
    align_scan();
    exp_q.push_back(KEY_STAR);
    keys[K_STAR] = 1'b1;
    wait_level(1'b1, 60, lat);
    check_range("star_latency", lat, 24, 34);
    check("star_code", {4'h0, key_code}, {4'h0, KEY_STAR});
    repeat (40) @(negedge clk);
    keys[K_STAR] = 1'b0;
    wait_level(1'b0, 60, lat);
    check("star_press_count", 8'(press_cnt - p0), 8'd1);
    check("star_rise_count", 8'(star_cnt - s0), 8'd1);
    check("star_code_cleared", {4'h0, key_code}, 8'h00);
    repeat (20) @(negedge clk);

    // '5' bouncing every 5 cycles never qualifies
    valid_seen = 1'b0;
    align_scan();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      keys[K_5] = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    keys[K_5] = 1'b0;
    repeat (60) @(negedge clk);
    check("bounce_valid_seen", {7'h0, valid_seen}, 8'h00);

    // '1' + '9' ghosted, then '1' alone
    valid_seen = 1'b0;
    keys[K_1] = 1'b1;
    keys[K_9] = 1'b1;
    repeat (100) @(negedge clk);
    check("ghost_valid_seen", {7'h0, valid_seen}, 8'h00);
    exp_q.push_back(4'h1);
    keys[K_9] = 1'b0;
    wait_level(1'b1, 60, lat);
    check("one_code", {4'h0, key_code}, 8'h01);
    keys[K_1] = 1'b0;
    wait_level(1'b0, 60, lat);
    repeat (20) @(negedge clk);

    // '#' held, one-scan glitch, then real release
    align_scan();
    exp_q.push_back(KEY_HASH);
    keys[K_HASH] = 1'b1;
    wait_level(1'b1, 60, lat);
    align_scan();
    repeat (6) @(negedge clk);
    valid_fell = 1'b0;
    keys[K_HASH] = 1'b0;
    repeat (8) @(negedge clk);
    keys[K_HASH] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid_kept", {7'h0, valid_fell}, 8'h00);
    check("glitch_code", {4'h0, key_code}, {4'h0, KEY_HASH});
    align_scan();
    repeat (6) @(negedge clk);
    keys[K_HASH] = 1'b0;
    wait_level(1'b0, 60, lat);
    check_range("hash_release_latency", lat, 24, 34);
    repeat (20) @(negedge clk);

    // '0' held across a reset pulse
    exp_q.push_back(KEY_0);
    keys[K_0] = 1'b1;
    wait_level(1'b1, 60, lat);
    check("zero_valid", {7'h0, key_valid}, 8'h01);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {7'h0, key_valid}, 8'h00);
    check("rst_mid_code", {4'h0, key_code}, 8'h00);
    check("rst_mid_col", {4'h0, col}, 8'h0E);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(KEY_0);
    wait_level(1'b1, 60, lat);
    check("rst_repress_code", {4'h0, key_code}, {4'h0, KEY_0});
    keys[K_0] = 1'b0;
    wait_level(1'b0, 60, lat);
    repeat (20) @(negedge clk);

    // 'A' held, 'B' added: no press for 'B' until both released
    exp_q.push_back(KEY_A);
    keys[K_A] = 1'b1;
    wait_level(1'b1, 60, lat);
    check("a_code", {4'h0, key_code}, {4'h0, KEY_A});
    keys[K_B] = 1'b1;
    repeat (80) @(negedge clk);
    check("ab_valid", {7'h0, key_valid}, 8'h00);
    keys = '0;
    repeat (30) @(negedge clk);
    exp_q.push_back(KEY_B);
    keys[K_B] = 1'b1;
    wait_level(1'b1, 60, lat);
    check("b_code", {4'h0, key_code}, {4'h0, KEY_B});
    keys[K_B] = 1'b0;
    wait_level(1'b0, 60, lat);
    repeat (10) @(negedge clk);

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    check("invariant_errors", 8'(inv_errs), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DWELL, default 2: clk cycles each column is driven before its rows are sampled (range 2..15).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 3: consecutive identical full scans needed to accept a press or release (range 1..7).
REQ-003 SHALL have port clk  input  1  system clock (1 kHz).
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low one-hot.
REQ-007 SHALL have port key_valid  output  1  high while a debounced key is held.
REQ-008 SHALL have port key_code  output  4  code of the debounced key; 0 when key_valid is low.
REQ-009 SHALL have port key_press  output  1  one-cycle pulse on each accepted press.
REQ-010 SHALL have port key_star_rise  output  1  one-cycle pulse when key_press fires with key_code 0xE; this feeds the downstream game-state FSM.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer before any use.
REQ-012 SHALL drive col as 1110, 1101, 1011, 0111 in rotation, holding each value for SCAN_DWELL cycles.
REQ-013 SHALL sample the synchronized row on the last dwell cycle of each column; a full scan takes 4*SCAN_DWELL cycles and ends with a one-cycle internal scan_done strobe.
REQ-014 SHALL map row r (0..3) and column c (0..3) to codes: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E(*),0,F(#),D.
REQ-015 SHALL take the raw scan result as "none" when zero keys or two or more keys are low in one scan (ghost rejection), and as that key's code otherwise.
REQ-016 SHALL run a debounce FSM that advances only on scan_done, with states IDLE, DEB_PRESS, HELD, DEB_REL and a 3-bit match counter.
REQ-017 IDLE: a raw key -> DEB_PRESS, latch candidate code, counter=1; none -> stay.
REQ-018 DEB_PRESS: raw equals candidate -> counter+1; when counter reaches DEBOUNCE_SCANS -> HELD. Raw differs -> IDLE.
REQ-019 On entry to HELD: key_valid=1, key_code=candidate, key_press pulses for exactly one cycle (the cycle after the qualifying scan_done), and key_star_rise pulses in that same cycle if the code is 0xE.
REQ-020 HELD: raw differs from held code (none or another key) -> DEB_REL, counter=1; raw equal -> stay.
REQ-021 DEB_REL: raw differs from held code -> counter+1; when counter reaches DEBOUNCE_SCANS -> IDLE and clear key_valid and key_code. Raw equals held code -> HELD, with no new key_press.
REQ-022 SHALL NOT let a new key pressed while another is held produce key_press until the held key has been released through IDLE.
REQ-023 SHALL keep key_valid and key_code stable between FSM transitions, and SHALL keep key_press and key_star_rise low in every other cycle.
REQ-024 With DEBOUNCE_SCANS=1, SHALL go IDLE->HELD on a single scan, skipping DEB_PRESS.

Reset
REQ-025 While rst_n is low: col=1110, key_valid=0, key_code=0, key_press=0, key_star_rise=0, FSM=IDLE, and dwell, column, match counters and synchronizer flops all 0/1 (synchronizer flops reset to 1).
REQ-026 Reset asserted mid-press or mid-hold SHALL drop all outputs at once; after release of reset, a key still held SHALL go through the full debounce and produce one key_press.

Structure
REQ-027 Key-code constants, FSM state encodings and default parameter values SHALL live in a shared package/header (keypad_defs), so that game-level blocks can compare against KEY_STAR.
REQ-028 The debounce FSM SHALL be one sub-module, keypad_debounce (inputs: scan_done, raw_valid, raw_code; outputs: key_valid, key_code, key_press); the scan counter, synchronizer and encoder stay in keypad_scanner.

Verification (defaults: scan = 8 cycles)
REQ-029 Hold '*' (row3 low when col=1110) steadily -> exactly one key_press and one key_star_rise pulse; key_code=0xE; key_valid rises 24..34 cycles after the press starts.
REQ-030 Toggle '5' every 5 cycles for 40 cycles, then release -> key_press never asserts and key_valid stays 0.
REQ-031 Press '1' and '9' together for 100 cycles -> key_valid=0 and no pulses; release '9' -> key '1' is accepted with key_code=0x1.
REQ-032 Hold '#' until HELD, then release -> key_valid falls within 24..34 cycles; a 1-scan release glitch inside HELD does not clear key_valid and does not re-pulse key_press.
REQ-033 Hold '0', assert rst_n low for 3 cycles during HELD, keep the key held -> outputs go 0 during reset, then one fresh key_press with key_code=0x0 follows.
REQ-034 Hold 'A', then press 'B' without releasing 'A' -> no key_press for 'B' until both keys are released and 'B' is pressed alone again.
